// File: rtl/conv_window_gen.sv
// Streaming sliding-window generator for the conv array.
// DW mode emits per-channel 3x3 windows from two row buffers; PW mode passes each pixel through as the centre tap.
module conv_window_gen #(
  parameter int CH_NUM      = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_ROW_LEN = 320,
  parameter int LEN_W       = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic [LEN_W-1:0]                 cfg_row_len,
  input  logic [LEN_W-1:0]                 cfg_row_num,
  input  logic                             cfg_stride2,
  input  logic                             cfg_pw_mode,
  input  logic [CH_NUM*DATA_WIDTH-1:0]     s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [CH_NUM*9*DATA_WIDTH-1:0]   m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             frame_done
);

  localparam int PIX_W  = CH_NUM * DATA_WIDTH;
  localparam int WIN_W  = PIX_W * 9;
  localparam int ADDR_W = (MAX_ROW_LEN > 1) ? $clog2(MAX_ROW_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO   = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_THREE = LEN_W'(3);

  typedef logic [DATA_WIDTH-1:0] sample_t;

  // Configuration registers
  logic [LEN_W-1:0] row_len_q, row_len_d;
  logic [LEN_W-1:0] row_num_q, row_num_d;
  logic             stride2_q, stride2_d;
  logic             pw_mode_q, pw_mode_d;

  // Position counters
  logic [LEN_W-1:0] col_cnt_q, col_cnt_d;
  logic [LEN_W-1:0] row_cnt_q, row_cnt_d;

  // Output stage
  logic [WIN_W-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             frame_done_q, frame_done_d;

  // Window shift registers, row buffers
  sample_t          win_q [CH_NUM][9];
  sample_t          win_d [CH_NUM][9];
  logic [PIX_W-1:0] rowbuf0_mem [MAX_ROW_LEN];
  logic [PIX_W-1:0] rowbuf1_mem [MAX_ROW_LEN];
  logic [PIX_W-1:0] rb0_rd, rb1_rd;
  logic [ADDR_W-1:0] rb_addr;

  logic accept, dw_acc, dw_ok, emit, last_col, last_row;
  logic [WIN_W-1:0] win_flat, pw_flat;

  assign s_ready    = !cfg_start && (!m_valid_q || m_ready);
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign frame_done = frame_done_q;

  assign accept   = s_valid && s_ready;
  assign dw_acc   = accept && !pw_mode_q;
  assign dw_ok    = (row_len_q >= LEN_THREE) && (row_num_q >= LEN_THREE);
  assign last_col = (col_cnt_q == row_len_q - LEN_ONE);
  assign last_row = (row_cnt_q == row_num_q - LEN_ONE);
  // With stride 2 the (row-2, col-2) parity test reduces to both counters being even.
  assign emit     = dw_ok && (row_cnt_q >= LEN_TWO) && (col_cnt_q >= LEN_TWO) &&
                    (!stride2_q || (!row_cnt_q[0] && !col_cnt_q[0]));

  assign rb_addr = ADDR_W'(col_cnt_q);
  assign rb0_rd  = rowbuf0_mem[rb_addr];
  assign rb1_rd  = rowbuf1_mem[rb_addr];

  always_comb begin
    for (int ch = 0; ch < CH_NUM; ch++) begin
      for (int k = 0; k < 9; k++) begin
        win_d[ch][k] = win_q[ch][k];
      end
    end
    if (dw_acc) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        // Column history is discarded at the start of a row so windows never span rows.
        for (int r = 0; r < 3; r++) begin
          if (col_cnt_q == '0) begin
            win_d[ch][r*3]   = '0;
            win_d[ch][r*3+1] = '0;
          end else begin
            win_d[ch][r*3]   = win_q[ch][r*3+1];
            win_d[ch][r*3+1] = win_q[ch][r*3+2];
          end
        end
        win_d[ch][2] = rb1_rd[ch*DATA_WIDTH +: DATA_WIDTH];
        win_d[ch][5] = rb0_rd[ch*DATA_WIDTH +: DATA_WIDTH];
        win_d[ch][8] = s_data[ch*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    pw_flat  = '0;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      for (int k = 0; k < 9; k++) begin
        win_flat[(ch*9+k)*DATA_WIDTH +: DATA_WIDTH] = win_d[ch][k];
      end
      pw_flat[(ch*9+4)*DATA_WIDTH +: DATA_WIDTH] = s_data[ch*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    row_len_d    = row_len_q;
    row_num_d    = row_num_q;
    stride2_d    = stride2_q;
    pw_mode_d    = pw_mode_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    frame_done_d = 1'b0;
    if (cfg_start) begin
      row_len_d = cfg_row_len;
      row_num_d = cfg_row_num;
      stride2_d = cfg_stride2;
      pw_mode_d = cfg_pw_mode;
      col_cnt_d = '0;
      row_cnt_d = '0;
    end else if (accept) begin
      if (last_col) begin
        col_cnt_d = '0;
        if (last_row) begin
          row_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          row_cnt_d = row_cnt_q + LEN_ONE;
        end
      end else begin
        col_cnt_d = col_cnt_q + LEN_ONE;
      end
    end
  end

  // Single output register: load on accept, drop when drained, hold under backpressure.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (cfg_start) begin
      m_valid_d = 1'b0;
    end else if (accept) begin
      if (pw_mode_q) begin
        m_valid_d = 1'b1;
        m_data_d  = pw_flat;
      end else if (emit) begin
        m_valid_d = 1'b1;
        m_data_d  = win_flat;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_len_q    <= LEN_THREE;
      row_num_q    <= LEN_THREE;
      stride2_q    <= 1'b0;
      pw_mode_q    <= 1'b0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_len_q    <= row_len_d;
      row_num_q    <= row_num_d;
      stride2_q    <= stride2_d;
      pw_mode_q    <= pw_mode_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Datapath storage carries no reset; the counters decide when its contents are meaningful.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < CH_NUM; ch++) begin
      for (int k = 0; k < 9; k++) begin
        win_q[ch][k] <= win_d[ch][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dw_acc) begin
      rowbuf1_mem[rb_addr] <= rb0_rd;
      rowbuf0_mem[rb_addr] <= s_data;
    end
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Parametrised successor to the conv pre-processing stage: a streaming sliding-window generator feeding the conv array.
- Accepts one pixel per beat, carrying CH_NUM parallel channels.
- DW mode: builds 3x3 windows per channel from two internal row buffers, with runtime row length, row count and stride 1/2.
- PW mode: passes each pixel through as a centre-tap window.
- Adds valid/ready backpressure on both sides and frame tracking.

Parameters:
CH_NUM, 9, parallel channels per pixel beat
DATA_WIDTH, 8, bits per channel sample
MAX_ROW_LEN, 320, row buffer depth (max pixels per row)
LEN_W, 9, width of row-length/row-count config and counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_start  in  1  pulse; samples all cfg_* inputs, clears counters and output valid
cfg_row_len  in  LEN_W  pixels per row, legal 3..MAX_ROW_LEN (DW)
cfg_row_num  in  LEN_W  rows per frame, legal >=3 (DW)
cfg_stride2  in  1  0 = stride 1, 1 = stride 2 (DW only)
cfg_pw_mode  in  1  1 = PW pass-through, 0 = DW 3x3
s_data  in  CH_NUM*DATA_WIDTH  pixel; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
m_data  out  CH_NUM*9*DATA_WIDTH  window; channel i tap k at [(i*9+k)*DATA_WIDTH +: DATA_WIDTH]
m_valid  out  1  window valid
m_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset: m_valid=0, m_data=0, frame_done=0; col_cnt=0, row_cnt=0; config registers = row_len 3, row_num 3, stride 1, DW mode.
- Row buffer RAM contents are not cleared; counters gate all use of stale data.
- Output stage is a single register: s_ready = !cfg_start & (!m_valid | m_ready).
- cfg_start:
  - Synchronously loads config, zeroes counters, clears m_valid and frame_done.
  - Any coincident input beat is dropped, because s_ready is 0 that cycle.
- Tap layout: tap k = r*3+c. r=0 is the oldest row and r=2 the current row; c=0 is the oldest column and c=2 the current pixel.
- DW accept at (row_cnt, col_cnt), per channel:
  - Shift the 3x3 window left by one column.
  - New column = {rowbuf1[col_cnt], rowbuf0[col_cnt], pixel} for rows 0, 1, 2.
  - Write rowbuf1[col_cnt] <= rowbuf0[col_cnt] and rowbuf0[col_cnt] <= pixel.
- DW emit condition: row_cnt>=2 & col_cnt>=2, and with stride 2 additionally row_cnt-2 and col_cnt-2 both even.
  - If met, m_data takes the updated window and m_valid=1 on the next cycle (latency 1).
  - If not met and m_ready=1, m_valid drops to 0.
- Window shift registers reset their column history at col_cnt=0. Windows never span rows (no padding; output size (W-3)/s+1 per row).
- PW accept: m_data tap 4 = pixel, all other taps 0; m_valid=1 next cycle for every accepted beat. Row buffers are untouched.
- Counters:
  - col_cnt increments per accepted beat and wraps to 0 at row_len-1, which increments row_cnt.
  - At the last pixel (row_num-1, row_len-1), row_cnt wraps to 0 and frame_done pulses next cycle.
  - The next frame starts immediately with the same config.
- m_data/m_valid hold stable while m_valid & !m_ready.
- Illegal config (DW row_len<3 or row_num<3): no windows emitted, counters still run, frame_done still pulses. row_len > MAX_ROW_LEN is undefined.
- Async rst mid-frame: immediate return to reset state; the first beat after release is pixel (0,0).

Test Plan:
- DW, CH_NUM=1, row_len=4, row_num=4, stride 1, pixel value = r*4+c, m_ready=1 -> exactly 4 windows. The first appears 1 cycle after beat 10 with taps 0,1,2,4,5,6,8,9,10. The last has taps 5,6,7,9,10,11,13,14,15. frame_done pulses once after beat 15.
- DW, 5x5 frame, stride2=1 -> 4 windows, centred at (1,1),(1,3),(3,1),(3,3); the first window's tap 4 = 6 and the last window's tap 4 = 18.
- Backpressure: hold m_ready=0 when the first window appears -> s_ready=0 next cycle, m_data frozen. Release after 5 cycles -> no window lost or duplicated; the sequence matches the first scenario.
- PW mode, 6 beats of values 1..6, CH_NUM=9 -> 6 outputs with tap 4 of each channel = 1..6, other taps 0, latency 1.
- cfg_start asserted mid-frame together with s_valid -> that beat is dropped. The next beats restart at (0,0), and the first window again matches the first scenario.
- Assert rst during row 2, then release -> m_valid=0 immediately. A full 4x4 frame then reproduces the first scenario exactly.
